inst_queue_ctrl: RTL and testbench

//  Instruction queue and issue scheduler between the instruction fetcher and the decoder.

---
 rtl/inst_queue_ctrl_if.sv | 31 +++
 rtl/inst_queue_ctrl.sv | 114 +++++++++++
 tb/tb_inst_queue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_ctrl_if.sv
// Fetcher/decoder-side handshake bundle for the instruction queue.
// The slave modport is the queue's view; master is the surrounding pipeline.
interface inst_queue_ctrl_if;
  logic        iIF_en;
  logic [31:0] iIF_inst;
  logic [31:0] iIF_pc;
  logic        iIF_pd;
  logic        oIF_full;
  logic        iROB_full;
  logic        iRS_full;
  logic        iLSB_full;
  logic        iROB_clear;
  logic        oDEC_en;
  logic [31:0] oDEC_inst;
  logic [31:0] oDEC_pc;
  logic        oDEC_pd;

  modport slave (
    input  iIF_en, iIF_inst, iIF_pc, iIF_pd,
    input  iROB_full, iRS_full, iLSB_full, iROB_clear,
    output oIF_full,
    output oDEC_en, oDEC_inst, oDEC_pc, oDEC_pd
  );

  modport master (
    output iIF_en, iIF_inst, iIF_pc, iIF_pd,
    output iROB_full, iRS_full, iLSB_full, iROB_clear,
    input  oIF_full,
    input  oDEC_en, oDEC_inst, oDEC_pc, oDEC_pd
  );
endinterface

// File: rtl/inst_queue_ctrl.sv
// Circular instruction queue between fetcher and decoder; issues at most one
// entry per cycle when the ROB and the target station (RS or LSB) have room.
module inst_queue_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  inst_queue_ctrl_if.slave   q
);

  localparam logic [6:0]     OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]     OPC_STORE = 7'b0100011;
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);

  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      pc_mem_q   [DEPTH];
  logic             pd_mem_q   [DEPTH];

  logic [PTR_W-1:0] head_q,  head_d;
  logic [PTR_W-1:0] tail_q,  tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             dec_en_q,   dec_en_d;
  logic [31:0]      dec_inst_q, dec_inst_d;
  logic [31:0]      dec_pc_q,   dec_pc_d;
  logic             dec_pd_q,   dec_pd_d;

  logic             full;
  logic             head_is_mem;
  logic             station_ok;
  logic             push_en;
  logic             pop_en;
  logic [6:0]       head_opc;

  assign full        = (count_q == FULL_CNT);
  assign head_opc    = inst_mem_q[head_q][6:0];
  assign head_is_mem = (head_opc == OPC_LOAD) || (head_opc == OPC_STORE);
  assign station_ok  = head_is_mem ? !q.iLSB_full : !q.iRS_full;

  // A push while full is dropped even if the head pops in the same cycle.
  assign push_en = rdy && q.iIF_en && !full && !q.iROB_clear;
  assign pop_en  = rdy && !q.iROB_clear && (count_q != '0) &&
                   !q.iROB_full && station_ok;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    dec_en_d   = 1'b0;
    dec_inst_d = dec_inst_q;
    dec_pc_d   = dec_pc_q;
    dec_pd_d   = dec_pd_q;

    if (rdy && q.iROB_clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop_en) begin
        head_d     = head_q + PTR_W'(1);
        dec_en_d   = 1'b1;
        dec_inst_d = inst_mem_q[head_q];
        dec_pc_d   = pc_mem_q[head_q];
        dec_pd_d   = pd_mem_q[head_q];
      end
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      dec_en_q   <= 1'b0;
      dec_inst_q <= '0;
      dec_pc_q   <= '0;
      dec_pd_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      dec_en_q   <= dec_en_d;
      dec_inst_q <= dec_inst_d;
      dec_pc_q   <= dec_pc_d;
      dec_pd_q   <= dec_pd_d;
    end
  end

  // Storage is not reset; occupancy is governed solely by count_q.
  always_ff @(posedge clk) begin
    if (push_en) begin
      inst_mem_q[tail_q] <= q.iIF_inst;
      pc_mem_q[tail_q]   <= q.iIF_pc;
      pd_mem_q[tail_q]   <= q.iIF_pd;
    end
  end

  assign q.oIF_full  = full;
  assign q.oDEC_en   = dec_en_q;
  assign q.oDEC_inst = dec_inst_q;
  assign q.oDEC_pc   = dec_pc_q;
  assign q.oDEC_pd   = dec_pd_q;

endmodule

// File: tb/tb_inst_queue_ctrl.sv
// Directed bench for inst_queue_ctrl: stimulus pushes expected entries into a
// scoreboard queue; a negedge monitor pops and compares every decoder issue.
module tb_inst_queue_ctrl;

  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] SW    = 32'h00112023;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pd;
  } ent_t;

  logic clk;
  logic rst;
  logic rdy;
  inst_queue_ctrl_if tif ();

  ent_t exp_q [$];
  int   total;
  int   bad;

  logic e_rob, e_rs, e_lsb, e_rdy, e_clr;

  inst_queue_ctrl #(.DEPTH(16), .PTR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .q   (tif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic pd, input logic accept);
    ent_t e;
    tif.iIF_en   = 1'b1;
    tif.iIF_inst = inst;
    tif.iIF_pc   = pc;
    tif.iIF_pd   = pd;
    if (accept) begin
      e.inst = inst;
      e.pc   = pc;
      e.pd   = pd;
      exp_q.push_back(e);
    end
  endtask

  // Inputs change 1ns after each rising edge, so they are stable here.
  always @(posedge clk) begin
    e_rob = tif.iROB_full;
    e_rs  = tif.iRS_full;
    e_lsb = tif.iLSB_full;
    e_rdy = rdy;
    e_clr = tif.iROB_clear;
  end

  always @(negedge clk) begin
    ent_t e;
    logic is_mem;
    if (tif.oDEC_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue_pc", tif.oDEC_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("issue_pc",   tif.oDEC_pc,   e.pc);
        chk("issue_inst", tif.oDEC_inst, e.inst);
        chk("issue_pd",   {31'b0, tif.oDEC_pd}, {31'b0, e.pd});
        chk("issue_rob_free", {31'b0, e_rob}, 32'd0);
        chk("issue_rdy",      {31'b0, e_rdy}, 32'd1);
        chk("issue_no_clear", {31'b0, e_clr}, 32'd0);
        is_mem = (e.inst[6:0] == 7'b0000011) || (e.inst[6:0] == 7'b0100011);
        chk("issue_station_free", {31'b0, (is_mem ? e_lsb : e_rs)}, 32'd0);
      end
    end
  end

  initial begin
    int k;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    rdy = 1'b1;
    tif.iIF_en     = 1'b1;
    tif.iIF_inst   = ADDI;
    tif.iIF_pc     = 32'h0;
    tif.iIF_pd     = 1'b0;
    tif.iROB_full  = 1'b0;
    tif.iRS_full   = 1'b0;
    tif.iLSB_full  = 1'b0;
    tif.iROB_clear = 1'b0;

    // Test 1: reset with fetch enable held, then single-entry latency
    #3;
    chk("rst_en",   {31'b0, tif.oDEC_en},   32'd0);
    chk("rst_inst", tif.oDEC_inst,          32'd0);
    chk("rst_pc",   tif.oDEC_pc,            32'd0);
    chk("rst_pd",   {31'b0, tif.oDEC_pd},   32'd0);
    chk("rst_full", {31'b0, tif.oIF_full},  32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_en", {31'b0, tif.oDEC_en}, 32'd0);
    drive(ADDI, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
    tick;
    tif.iIF_en = 1'b0;
    chk("t1_not_yet", {31'b0, tif.oDEC_en}, 32'd0);
    tick;
    chk("t1_en",   {31'b0, tif.oDEC_en}, 32'd1);
    chk("t1_inst", tif.oDEC_inst, ADDI);
    chk("t1_pc",   tif.oDEC_pc,   32'h0);
    tick;
    chk("t1_one_cycle", {31'b0, tif.oDEC_en}, 32'd0);

    // Test 2: fill to 16, drop 17th, drain in order one per cycle
    tif.iRS_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(ADDI, 32'(i * 4), i[0], 1'b1);
      tick;
      if (i == 14) chk("t2_not_full_15", {31'b0, tif.oIF_full}, 32'd0);
      if (i == 15) chk("t2_full_16",     {31'b0, tif.oIF_full}, 32'd1);
    end
    drive(ADDI, 32'h40, 1'b0, 1'b0);
    tick;
    chk("t2_full_after_drop", {31'b0, tif.oIF_full}, 32'd1);
    chk("t2_no_issue_rs", {31'b0, tif.oDEC_en}, 32'd0);
    tif.iIF_en   = 1'b0;
    tif.iRS_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("t2_drain_en", {31'b0, tif.oDEC_en}, 32'd1);
      chk("t2_drain_pc", tif.oDEC_pc, 32'(i * 4));
      if (i == 0) chk("t2_full_clears", {31'b0, tif.oIF_full}, 32'd0);
    end
    tick;
    chk("t2_dropped_absent", {31'b0, tif.oDEC_en}, 32'd0);

    // Test 3: load blocked by LSB, younger add waits behind it
    tif.iLSB_full = 1'b1;
    drive(LW, 32'h100, 1'b0, 1'b1);
    tick;
    drive(ADD, 32'h104, 1'b1, 1'b1);
    tick;
    tif.iIF_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t3_lsb_block", {31'b0, tif.oDEC_en}, 32'd0);
    end
    tif.iLSB_full = 1'b0;
    tick;
    chk("t3_lw_en", {31'b0, tif.oDEC_en}, 32'd1);
    chk("t3_lw_pc", tif.oDEC_pc, 32'h100);
    tick;
    chk("t3_add_en", {31'b0, tif.oDEC_en}, 32'd1);
    chk("t3_add_pc", tif.oDEC_pc, 32'h104);
    tick;
    chk("t3_idle", {31'b0, tif.oDEC_en}, 32'd0);

    // Test 4: flush with entries queued and one just issued
    tif.iRS_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(ADDI, 32'h300 + 32'(i * 4), 1'b0, 1'b1);
      tick;
    end
    tif.iIF_en   = 1'b0;
    tif.iRS_full = 1'b0;
    tick;
    chk("t4_pre_en", {31'b0, tif.oDEC_en}, 32'd1);
    chk("t4_pre_pc", tif.oDEC_pc, 32'h300);
    tif.iROB_clear = 1'b1;
    drive(ADDI, 32'h400, 1'b0, 1'b0);
    tick;
    exp_q.delete();
    chk("t4_flush_en",   {31'b0, tif.oDEC_en},  32'd0);
    chk("t4_flush_full", {31'b0, tif.oIF_full}, 32'd0);
    tif.iROB_clear = 1'b0;
    tif.iIF_en     = 1'b0;
    tick;
    chk("t4_empty_after_flush", {31'b0, tif.oDEC_en}, 32'd0);
    drive(ADDI, 32'h200, 1'b0, 1'b1);
    tick;
    tif.iIF_en = 1'b0;
    tick;
    chk("t4_next_en", {31'b0, tif.oDEC_en}, 32'd1);
    chk("t4_next_pc", tif.oDEC_pc, 32'h200);
    tick;

    // Test 5: 40-entry stream with ROB backpressure toggling every 3 cycles
    k = 0;
    for (int c = 0; c < 120; c++) begin
      tif.iROB_full = ((c / 3) % 2) == 1;
      if ((c % 2) == 0 && k < 40) begin
        drive(((k % 3) == 0) ? SW : ADDI, 32'h1000 + 32'(k * 4), k[1], 1'b1);
        k++;
      end else begin
        tif.iIF_en = 1'b0;
      end
      tick;
    end
    tif.iIF_en    = 1'b0;
    tif.iROB_full = 1'b0;
    repeat (4) tick;
    chk("t5_all_issued", 32'(exp_q.size()), 32'd0);

    // Test 6: pause for 4 cycles mid-stream
    k = 0;
    for (int c = 0; c < 30; c++) begin
      rdy = !(c >= 8 && c < 12);
      if (k < 16) begin
        drive(ADDI, 32'h2000 + 32'(k * 4), 1'b0, rdy);
        if (rdy) k++;
      end else begin
        tif.iIF_en = 1'b0;
      end
      tick;
      if (c >= 8 && c < 12) chk("t6_paused_en", {31'b0, tif.oDEC_en}, 32'd0);
    end
    rdy = 1'b1;
    tif.iIF_en = 1'b0;
    repeat (3) tick;
    chk("t6_all_issued", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-stream
    tif.iRS_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ADDI, 32'h3000 + 32'(i * 4), 1'b0, 1'b1);
      tick;
    end
    tif.iIF_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_en",   {31'b0, tif.oDEC_en},  32'd0);
    chk("arst_inst", tif.oDEC_inst,         32'd0);
    chk("arst_pc",   tif.oDEC_pc,           32'd0);
    chk("arst_pd",   {31'b0, tif.oDEC_pd},  32'd0);
    chk("arst_full", {31'b0, tif.oIF_full}, 32'd0);
    exp_q.delete();
    tick;
    rst = 1'b0;
    tif.iRS_full = 1'b0;
    tick;
    chk("arst_empty", {31'b0, tif.oDEC_en}, 32'd0);
    drive(ADDI, 32'h500, 1'b1, 1'b1);
    tick;
    tif.iIF_en = 1'b0;
    tick;
    chk("arst_resume_en", {31'b0, tif.oDEC_en}, 32'd1);
    chk("arst_resume_pc", tif.oDEC_pc, 32'h500);
    repeat (2) tick;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
